// File: rtl/aes_job_scheduler.sv
// Two-requester round-robin front end for a single AES core: accepts one job,
// runs it with a done/timeout race, and holds the response until it is taken.
module aes_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         core_start,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_ciphertext,
  input  logic         core_done,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // requester ready is only offered in IDLE, response valid only in RESP.
  logic [1:0]   r_state;
  logic         r_last_grant;
  logic [7:0]   r_cnt;
  logic [127:0] r_pt;
  logic [127:0] r_key;
  logic [127:0] r_data;
  logic         r_id;
  logic         r_timeout;

  logic w_idle;
  logic w_grant;
  logic w_accept;
  logic w_done_ok;
  logic w_timeout_hit;

  assign w_idle  = (r_state == S_IDLE);
  // With both pending, the requester not served last goes first.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_accept   = req0_ready || req1_ready;

  // A done seen in the first RUN cycle may be left over from a previous job.
  assign w_done_ok     = (r_state == S_RUN) && core_done && (r_cnt != 8'd0);
  assign w_timeout_hit = (r_state == S_RUN) && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_pt         <= '0;
      r_key        <= '0;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_pt    <= w_grant ? req1_pt : req0_pt;
            r_key   <= w_grant ? req1_key : req0_key;
            r_id    <= w_grant;
            r_cnt   <= 8'd0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done_ok) begin
            r_data    <= core_ciphertext;
            r_timeout <= 1'b0;
            r_state   <= S_RESP;
          end else if (w_timeout_hit) begin
            r_data    <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_last_grant <= r_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start     = (r_state == S_RUN);
  assign core_plaintext = r_pt;
  assign core_key       = r_key;
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_id         = r_id;
  assign rsp_data       = r_data;
  assign rsp_timeout    = r_timeout;
  assign busy           = !w_idle;
  assign dbg_state      = r_state;

endmodule
